// File: rtl/timer_counter.sv
// timer_counter: memory-mapped programmable down-counter with one-shot/auto-reload modes and maskable irq
module timer_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] CNT  = 2'd2;
  localparam logic [1:0] INT  = 2'd3;
  logic [1:0]  state;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;
  logic        wr_ctrl;
  logic        wr_preset;
  assign wr_ctrl   = we && addr == 2'd0;
  assign wr_preset = we && addr == 2'd1;
  assign irq       = irq_flag & ctrl[3];
  assign dout      = addr == 2'd0 ? {28'd0, ctrl} : addr == 2'd1 ? preset : addr == 2'd2 ? count : 32'd0;
  // CPU writes come after the FSM so they win over the hardware EN clear and flag set
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: if (ctrl[0]) state <= LOAD;
        LOAD: begin
          state <= ctrl[0] ? CNT : IDLE;
          if (ctrl[0]) count <= preset;
        end
        CNT: begin
          if (!ctrl[0]) state <= IDLE;
          else if (count > 32'd1) count <= count - 32'd1;
          else begin
            count    <= '0;
            irq_flag <= 1'b1;
            state    <= INT;
          end
        end
        INT: begin
          state <= IDLE;
          if (ctrl[2:1] == 2'b01) irq_flag <= 1'b0;
          else ctrl[0] <= 1'b0;
        end
      endcase
      if (wr_ctrl) ctrl <= din[3:0];
      if (wr_preset) preset <= din;
      if (wr_ctrl || wr_preset) irq_flag <= 1'b0;
    end
  end
endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: vector table, hand sequences and randomized run against a reference model
module tb_timer_counter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  addr = '0;
  logic        we = 1'b0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic        irq;
  int errs = 0;
  int checks = 0;

  timer_counter dut (.clk(clk), .reset(reset), .addr(addr), .we(we), .din(din), .dout(dout), .irq(irq));

  always #5 clk = ~clk;

  typedef struct {
    bit          w;
    logic [1:0]  a;
    logic [31:0] d;
    bit          r;
    logic [3:0]  e_ctrl;
    logic [31:0] e_preset;
    logic [31:0] e_count;
    bit          e_irq;
  } vec_t;
  vec_t tv[28];

  // Reference model: the timer's observable registers plus which activity it is engaged in
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset, m_count;
  bit          m_flag;
  bit          m_loading, m_counting, m_expired;

  function automatic void model_step(input bit w, input logic [1:0] a, input logic [31:0] d, input bit r);
    logic [3:0]  c = m_ctrl;
    logic [31:0] n = m_count;
    bit f = m_flag, ld = 1'b0, cn = 1'b0, ex = 1'b0;
    bit en = m_ctrl[0];
    if (r) begin
      m_ctrl = '0; m_preset = '0; m_count = '0; m_flag = 0;
      m_loading = 0; m_counting = 0; m_expired = 0;
      return;
    end
    if (m_expired) begin
      if (m_ctrl[2:1] == 2'b01) f = 0;
      else c[0] = 0;
    end else if (m_counting) begin
      if (en && m_count >= 2) begin n = m_count - 1; cn = 1; end
      else if (en) begin n = 0; f = 1; ex = 1; end
    end else if (m_loading) begin
      if (en) begin n = m_preset; cn = 1; end
    end else ld = en;
    if (w && a == 2'd0) c = d[3:0];
    if (w && a == 2'd1) m_preset = d;
    if (w && a <= 2'd1) f = 0;
    m_ctrl = c; m_count = n; m_flag = f;
    m_loading = ld; m_counting = cn; m_expired = ex;
  endfunction

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    case (a)
      2'd0: return {28'd0, m_ctrl};
      2'd1: return m_preset;
      2'd2: return m_count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle(input bit w, input logic [1:0] a, input logic [31:0] d, input bit r);
    we = w; addr = a; din = d; reset = r;
    @(posedge clk);
    model_step(w, a, d, r);
    #1;
    we = 1'b0; reset = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = dout;
  endtask

  initial begin
    logic [31:0] v;
    bit found;
    tv[0]  = '{0, 0, 0, 1, 4'h0, 0, 0, 0};
    tv[1]  = '{1, 1, 3, 0, 4'h0, 3, 0, 0};
    tv[2]  = '{1, 0, 9, 0, 4'h9, 3, 0, 0};
    tv[3]  = '{0, 0, 0, 0, 4'h9, 3, 0, 0};
    tv[4]  = '{0, 0, 0, 0, 4'h9, 3, 3, 0};
    tv[5]  = '{0, 0, 0, 0, 4'h9, 3, 2, 0};
    tv[6]  = '{0, 0, 0, 0, 4'h9, 3, 1, 0};
    tv[7]  = '{0, 0, 0, 0, 4'h9, 3, 0, 1};
    tv[8]  = '{0, 0, 0, 0, 4'h8, 3, 0, 1};
    tv[9]  = '{0, 0, 0, 0, 4'h8, 3, 0, 1};
    tv[10] = '{1, 0, 0, 0, 4'h0, 3, 0, 0};
    tv[11] = '{1, 1, 7, 0, 4'h0, 7, 0, 0};
    tv[12] = '{1, 2, 5, 0, 4'h0, 7, 0, 0};
    tv[13] = '{1, 3, 32'hff, 0, 4'h0, 7, 0, 0};
    tv[14] = '{1, 1, 2, 0, 4'h0, 2, 0, 0};
    tv[15] = '{1, 0, 1, 0, 4'h1, 2, 0, 0};
    tv[16] = '{0, 0, 0, 0, 4'h1, 2, 0, 0};
    tv[17] = '{0, 0, 0, 0, 4'h1, 2, 2, 0};
    tv[18] = '{0, 0, 0, 0, 4'h1, 2, 1, 0};
    tv[19] = '{0, 0, 0, 0, 4'h1, 2, 0, 0};
    tv[20] = '{0, 0, 0, 0, 4'h0, 2, 0, 0};
    tv[21] = '{1, 0, 8, 0, 4'h8, 2, 0, 0};
    tv[22] = '{1, 1, 0, 0, 4'h8, 0, 0, 0};
    tv[23] = '{1, 0, 9, 0, 4'h9, 0, 0, 0};
    tv[24] = '{0, 0, 0, 0, 4'h9, 0, 0, 0};
    tv[25] = '{0, 0, 0, 0, 4'h9, 0, 0, 0};
    tv[26] = '{0, 0, 0, 0, 4'h9, 0, 0, 1};
    tv[27] = '{0, 0, 0, 0, 4'h8, 0, 0, 1};
    for (int i = 0; i < 28; i++) begin
      cycle(tv[i].w, tv[i].a, tv[i].d, tv[i].r);
      rd(2'd0, v); chk($sformatf("vec%0d ctrl", i), v, {28'd0, tv[i].e_ctrl});
      rd(2'd1, v); chk($sformatf("vec%0d preset", i), v, tv[i].e_preset);
      rd(2'd2, v); chk($sformatf("vec%0d count", i), v, tv[i].e_count);
      rd(2'd3, v); chk($sformatf("vec%0d unused", i), v, 32'd0);
      chk($sformatf("vec%0d irq", i), {31'd0, irq}, {31'd0, tv[i].e_irq});
    end
    // auto-reload: PRESET=2 gives a one-cycle irq pulse every 5 cycles, EN never drops
    cycle(0, 0, 0, 1);
    cycle(1, 1, 2, 0);
    cycle(1, 0, 32'hB, 0);
    for (int k = 1; k <= 20; k++) begin
      cycle(0, 0, 0, 0);
      chk($sformatf("reload irq k%0d", k), {31'd0, irq}, {31'd0, k >= 4 && (k - 4) % 5 == 0});
      rd(2'd0, v); chk($sformatf("reload ctrl k%0d", k), v, 32'hB);
    end
    // pause at 6, then re-enable reloads PRESET
    cycle(0, 0, 0, 1);
    cycle(1, 1, 10, 0);
    cycle(1, 0, 1, 0);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      cycle(0, 0, 0, 0);
      rd(2'd2, v);
      found = v == 32'd7;
    end
    chk("pause reached 7", {31'd0, found}, 32'd1);
    cycle(1, 0, 0, 0);
    rd(2'd2, v); chk("pause count", v, 32'd6);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 0, 0, 0);
      rd(2'd2, v); chk($sformatf("pause hold%0d", k), v, 32'd6);
    end
    cycle(1, 0, 1, 0);
    cycle(0, 0, 0, 0);
    rd(2'd2, v); chk("resume load cycle", v, 32'd6);
    cycle(0, 0, 0, 0);
    rd(2'd2, v); chk("resume reload", v, 32'd10);
    // reset while counting
    cycle(1, 1, 100, 0);
    cycle(1, 0, 9, 0);
    for (int k = 0; k < 5; k++) cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], v); chk($sformatf("rst reg%0d", a), v, 32'd0);
    end
    chk("rst irq", {31'd0, irq}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 0, 0, 0);
      rd(2'd2, v); chk($sformatf("rst idle count%0d", k), v, 32'd0);
    end
    // randomized traffic against the model
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 500; i++) begin
      bit r, w;
      logic [1:0] a;
      logic [31:0] d;
      r = $urandom_range(0, 63) == 0;
      w = $urandom_range(0, 2) == 0;
      a = 2'($urandom_range(0, 3));
      d = $urandom;
      if (a == 2'd1) d = $urandom_range(0, 5);
      if (a == 2'd0) d[0] = $urandom_range(0, 3) != 0;
      cycle(w, a, d, r);
      for (int j = 0; j < 4; j++) begin
        rd(j[1:0], v); chk($sformatf("rand%0d reg%0d", i, j), v, model_rd(j[1:0]));
      end
      chk($sformatf("rand%0d irq", i), {31'd0, irq}, {31'd0, m_flag & m_ctrl[3]});
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/timer_counter.md
# timer_counter

Memory-mapped programmable down-counter on the CPU data bus, occupying one 16-byte window: base 0x7F00 for timer 0, 0x7F10 for timer 1. The CPU reaches it through its data-bus address, write-data and byte-enable outputs, after system-bridge decode. It supplies one bit of the external hardware-interrupt vector returned to the CPU. It implements one-shot and auto-reload modes with a maskable interrupt.

## Interface
Parameters:
- none; the base address is decoded outside this block.

Ports:
- clk  in  1  system clock; every register updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- addr  in  2  word offset inside the window (data-bus address bits [3:2]).
- we  in  1  write strobe, already qualified by window decode and byte enable 4'b1111.
- din  in  32  write data.
- dout  out  32  read data, combinational from `addr`.
- irq  out  1  interrupt request to the CPU, level, equal to `irq_flag & CTRL.IM`.

## Operation
Registers (offset: name):
- 0x0: CTRL, read/write.
  - bit0 EN: counting enable.
  - bits[2:1] MODE: 00 one-shot, 01 auto-reload; 10 and 11 behave as 00.
  - bit3 IM: interrupt mask, 1 = irq allowed.
  - bits[31:4] read 0 and ignore writes.
- 0x4: PRESET, read/write, 32 bits.
- 0x8: COUNT, read-only; writes are ignored.
- 0xC: unused; reads 0 and ignores writes.

Writes:
- A write with `we` = 1 updates the addressed register at the clock edge.
- A write to CTRL or PRESET also clears `irq_flag` at that same edge.

FSM states: IDLE, LOAD, CNT, INT.
- IDLE:
  - EN = 1 → LOAD.
  - Otherwise stay; COUNT holds its value.
- LOAD:
  - COUNT ← PRESET; → CNT.
  - If EN = 0 at this edge → IDLE, and COUNT is not loaded.
- CNT:
  - EN = 0 → IDLE; COUNT freezes.
  - COUNT > 1 → COUNT ← COUNT − 1; stay in CNT.
  - COUNT ≤ 1 → COUNT ← 0, `irq_flag` ← 1, → INT.
- INT:
  - MODE ≠ 01: CTRL.EN ← 0, → IDLE; `irq_flag` stays 1.
  - MODE = 01: `irq_flag` ← 0, → IDLE. EN is still 1, so the counter reloads automatically.

Boundary rules:
- PRESET = 0 behaves like PRESET = 1: the counter expires one cycle after LOAD.
- A CPU write to CTRL in the INT state at the same edge as the hardware clear of EN: the CPU write wins.
- A PRESET write during CNT does not affect the current count; it takes effect at the next LOAD.
- COUNT is unsigned; there is no wrap below 0.
- Reset mid-count: all registers and the state return to reset values at the next edge, and irq drops.

## Timing
- Reset values:
  - CTRL = 0, PRESET = 0, COUNT = 0.
  - State = IDLE, `irq_flag` = 0.
  - Outputs: `irq` = 0, `dout` = 0.
- `dout` is combinational, with zero latency, and reflects register contents after the last edge.
- Timeline for a CTRL write with EN = 1 at edge e0:
  - e1: IDLE → LOAD.
  - e2: COUNT = PRESET.
  - Each following edge decrements COUNT.
- With PRESET = N ≥ 1, `irq_flag` rises at edge e2 + N − 1 + 1 = e(N+2) and is visible the cycle after that edge.
- Auto-reload: irq is high for exactly 1 cycle, and the period is N + 3 cycles (LOAD + N CNT + INT + IDLE).
- One-shot: irq stays high until the next CTRL/PRESET write or reset.

## Test plan
- One-shot with interrupt:
  - Stimulus: write PRESET = 3, then CTRL = 0x9 at e0.
  - Required response: COUNT reads 3, 2, 1, 0 at e2…e5; `irq` = 1 from e5; CTRL reads 0x8 after e6; writing CTRL = 0 clears `irq`.
- Auto-reload:
  - Stimulus: PRESET = 2, CTRL = 0xB.
  - Required response: `irq` pulses for 1 cycle every 5 cycles; CTRL.EN stays 1.
- Masked interrupt:
  - Stimulus: PRESET = 2, CTRL = 0x1.
  - Required response: COUNT reaches 0, `irq` stays 0, and `irq_flag` is set. A later CTRL write of 0x8 leaves `irq` at 0, because the write clears the flag.
- Pause/resume:
  - Stimulus: PRESET = 10, CTRL = 0x1; write CTRL = 0 while COUNT = 6.
  - Required response: COUNT holds 6. Re-enabling reloads 10, per the IDLE→LOAD rule.
- Illegal access:
  - Stimulus: write offset 0x8 with 5, and write offset 0xC.
  - Required response: COUNT is unchanged, and offset 0xC reads 0.
- Reset mid-count:
  - Stimulus: PRESET = 100, counting, assert `reset` for 1 cycle.
  - Required response: all registers read 0, `irq` = 0, and the counter stays in IDLE.
